// File: rtl/window_3x3_gen_if.sv
// Pixel-stream / window-stream bundle for window_3x3_gen.
// The pixel side has no ready: a pixel is taken on every rising clock edge
// where pix_valid is high, and the producer must not expect backpressure.
// The window side has no ready either: window_valid marks a one-cycle
// presentation of color_data/win_x/win_y that the consumer must take.
interface window_3x3_gen_if #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [11:0]   pix_in;
    logic          pix_valid;
    logic          sof;
    logic [107:0]  color_data;
    logic          window_valid;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic          frame_done;

    // Pixel source side (drives the stream, observes the windows)
    modport master (
        output pix_in, pix_valid, sof,
        input  color_data, window_valid, win_x, win_y, frame_done
    );

    // Window generator side
    modport slave (
        input  pix_in, pix_valid, sof,
        output color_data, window_valid, win_x, win_y, frame_done
    );
endinterface

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator for a raster RGB444 pixel stream.
// Two line buffers keep the previous two rows; each accepted pixel pushes a
// new 3-pixel column (row r-2, row r-1, row r) into a 3-column window. When the
// accepted pixel completes an interior neighbourhood, the window centred one
// column left and one row up is registered onto the outputs (latency 1).
module window_3x3_gen #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic             clk,
    input  logic             reset,
    window_3x3_gen_if.slave  win_if
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    // Position of the next pixel to be accepted
    logic [XW-1:0] c_q, c_d;
    logic [YW-1:0] r_q, r_d;

    // Position of the pixel being accepted this cycle (sof forces origin)
    logic [XW-1:0] cx;
    logic [YW-1:0] ry;
    logic          accept;
    logic          qualify;
    logic          last_pix;

    // Line buffers: near holds row r-1, far holds row r-2, indexed by column
    logic [11:0] lb_near_q [IMG_W];
    logic [11:0] lb_far_q  [IMG_W];

    // Window columns, index 0 = leftmost (oldest). Each column is
    // {top (row r-2), mid (row r-1), bot (row r)}.
    logic [35:0] col_q [3];
    logic [35:0] col_d [3];
    logic [35:0] new_col;

    // Registered outputs
    logic [107:0]  color_q, color_d;
    logic          valid_q;
    logic [XW-1:0] win_x_q, win_x_d;
    logic [YW-1:0] win_y_q, win_y_d;
    logic          done_q;

    assign accept   = win_if.pix_valid;
    assign cx       = win_if.sof ? '0 : c_q;
    assign ry       = win_if.sof ? '0 : r_q;
    assign qualify  = accept && (cx >= XW'(2)) && (ry >= YW'(2));
    assign last_pix = accept && (cx == XW'(IMG_W - 1)) && (ry == YW'(IMG_H - 1));
    assign new_col  = {lb_far_q[cx], lb_near_q[cx], win_if.pix_in};

    // Raster counters: advance on accept, wrap at line and frame end
    always_comb begin
        c_d = c_q;
        r_d = r_q;
        if (accept) begin
            if (cx == XW'(IMG_W - 1)) begin
                c_d = '0;
                r_d = (ry == YW'(IMG_H - 1)) ? '0 : ry + YW'(1);
            end else begin
                c_d = cx + XW'(1);
                r_d = ry;
            end
        end
    end

    // Counter state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_q <= '0;
            r_q <= '0;
        end else begin
            c_q <= c_d;
            r_q <= r_d;
        end
    end

    // Line buffers: on accept, row r-1 at this column ages into row r-2 and
    // the new pixel becomes row r-1 for the next line. Contents need no reset
    // because no window is emitted until both rows are rewritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_far_q[cx]  <= lb_near_q[cx];
            lb_near_q[cx] <= win_if.pix_in;
        end
    end

    // Window shift: drop the leftmost column, append the fresh column
    always_comb begin
        col_d[0] = col_q[0];
        col_d[1] = col_q[1];
        col_d[2] = col_q[2];
        if (accept) begin
            col_d[0] = col_q[1];
            col_d[1] = col_q[2];
            col_d[2] = new_col;
        end
    end

    // Window column registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q[0] <= '0;
            col_q[1] <= '0;
            col_q[2] <= '0;
        end else begin
            col_q[0] <= col_d[0];
            col_q[1] <= col_d[1];
            col_q[2] <= col_d[2];
        end
    end

    // Output packing from the post-shift window; hold previous values unless
    // this accept completes an interior window. Columns 0..2 were all shifted
    // in at cx-2..cx of the current line, so rows never mix across a wrap.
    always_comb begin
        color_d = color_q;
        win_x_d = win_x_q;
        win_y_d = win_y_q;
        if (qualify) begin
            color_d = {col_d[1][23:12],   // center
                       col_d[0][23:12],   // left
                       col_d[2][23:12],   // right
                       col_d[1][35:24],   // up
                       col_d[1][11:0],    // down
                       col_d[0][35:24],   // up-left
                       col_d[2][35:24],   // up-right
                       col_d[0][11:0],    // down-left
                       col_d[2][11:0]};   // down-right
            win_x_d = cx - XW'(1);
            win_y_d = ry - YW'(1);
        end
    end

    // Output registers: valid and frame_done are single-cycle pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            color_q <= '0;
            valid_q <= 1'b0;
            win_x_q <= '0;
            win_y_q <= '0;
            done_q  <= 1'b0;
        end else begin
            color_q <= color_d;
            valid_q <= qualify;
            win_x_q <= win_x_d;
            win_y_q <= win_y_d;
            done_q  <= last_pix;
        end
    end

    assign win_if.color_data   = color_q;
    assign win_if.window_valid = valid_q;
    assign win_if.win_x        = win_x_q;
    assign win_if.win_y        = win_y_q;
    assign win_if.frame_done   = done_q;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x4 image.
// A frame-image model computes each expected window straight from the pixels
// the bench has sent; a negedge compare process checks every cycle.
module tb_window_3x3_gen;
  localparam int W = 4;
  localparam int H = 4;
  // Expected entry: {frame_done, window_valid, win_x[1:0], win_y[1:0], data}
  localparam int EW = 114;

  logic clk;
  logic reset;

  window_3x3_gen_if #(.IMG_W(W), .IMG_H(H)) ifc ();

  window_3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk    (clk),
    .reset  (reset),
    .win_if (ifc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached act=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int win_cnt  = 0;
  int fd_cnt   = 0;
  logic          got_first = 1'b0;
  logic [107:0]  first_data;
  logic [1:0]    first_x;
  logic [1:0]    first_y;

  // model: image of the current frame and raster position of next pixel
  logic [11:0] img [H][W];
  int pos = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
  endtask

  // window centred at (x,y) of the model image, in output packing order
  function automatic logic [107:0] build(input int x, input int y);
    return {img[y][x], img[y][x-1], img[y][x+1], img[y-1][x], img[y+1][x],
            img[y-1][x-1], img[y-1][x+1], img[y+1][x-1], img[y+1][x+1]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifc.pix_valid = 1'b0;
      ifc.sof       = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic send_pix(input logic [11:0] d, input logic s, input int gap);
    int x;
    int y;
    logic v;
    logic fd;
    logic [107:0] wd;
    idle(gap);
    @(negedge clk);
    ifc.pix_in    = d;
    ifc.pix_valid = 1'b1;
    ifc.sof       = s;
    @(posedge clk);
    if (s) pos = 0;
    x = pos % W;
    y = pos / W;
    img[y][x] = d;
    v  = (x >= 2) && (y >= 2);
    fd = (pos == W * H - 1);
    wd = v ? build(x - 1, y - 1) : '0;
    exp_q.push_back({fd, v, 2'(x - 1), 2'(y - 1), wd});
    pos = (pos + 1) % (W * H);
  endtask

  // one frame with pixel tag t: p(x,y) = {t, y, x}; gap<0 means random 1..5
  task automatic send_frame(input logic [3:0] t, input logic s, input int gap);
    for (int k = 0; k < W * H; k++) begin
      int g;
      g = (gap < 0 && k > 0) ? int'($urandom_range(1, 5)) : 0;
      send_pix({t, 4'(k / W), 4'(k % W)}, s && (k == 0), g);
    end
  endtask

  task automatic drain_and_clear();
    idle(3);
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic start_test();
    win_cnt   = 0;
    fd_cnt    = 0;
    got_first = 1'b0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("window_valid", 128'(ifc.window_valid), 128'(e[112]));
      chk("frame_done", 128'(ifc.frame_done), 128'(e[113]));
      if (e[112]) begin
        chk("color_data", 128'(ifc.color_data), 128'(e[107:0]));
        chk("win_x", 128'(ifc.win_x), 128'(e[111:110]));
        chk("win_y", 128'(ifc.win_y), 128'(e[109:108]));
      end
    end else begin
      chk("idle_window_valid", 128'(ifc.window_valid), 128'd0);
      chk("idle_frame_done", 128'(ifc.frame_done), 128'd0);
    end
    if (ifc.window_valid) begin
      win_cnt++;
      chk("border_center", 128'((ifc.win_x == 2'd0) || (ifc.win_x == 2'd3) ||
                                (ifc.win_y == 2'd0) || (ifc.win_y == 2'd3)), 128'd0);
      if (!got_first) begin
        got_first  = 1'b1;
        first_data = ifc.color_data;
        first_x    = ifc.win_x;
        first_y    = ifc.win_y;
      end
    end
    if (ifc.frame_done) fd_cnt++;
  end

  // ---------------- main sequence ----------------
  initial begin
    reset         = 1'b0;
    ifc.pix_in    = '0;
    ifc.pix_valid = 1'b0;
    ifc.sof       = 1'b0;
    #3;
    chk("reset_color", 128'(ifc.color_data), 128'd0);
    chk("reset_valid", 128'(ifc.window_valid), 128'd0);
    chk("reset_xy", 128'({ifc.win_x, ifc.win_y}), 128'd0);
    chk("reset_done", 128'(ifc.frame_done), 128'd0);
    #9 reset = 1'b1;

    // continuous frame with sof
    start_test();
    send_frame(4'h0, 1'b1, 0);
    drain_and_clear();
    chk("t1_windows", 128'(win_cnt), 128'd4);
    chk("t1_frame_done", 128'(fd_cnt), 128'd1);
    chk("t1_first_data", 128'(first_data), 128'h011010012001021000002020022);
    chk("t1_first_xy", 128'({first_x, first_y}), 128'({2'd1, 2'd1}));

    // same frame with random stalls
    start_test();
    send_frame(4'h0, 1'b1, -1);
    drain_and_clear();
    chk("t2_windows", 128'(win_cnt), 128'd4);
    chk("t2_frame_done", 128'(fd_cnt), 128'd1);
    chk("t2_first_data", 128'(first_data), 128'h011010012001021000002020022);

    // two back-to-back frames, sof only on the first
    start_test();
    send_frame(4'h0, 1'b1, 0);
    send_frame(4'h1, 1'b0, 0);
    drain_and_clear();
    chk("t3_windows", 128'(win_cnt), 128'd8);
    chk("t3_frame_done", 128'(fd_cnt), 128'd2);

    // abort at old-frame position (1,2) by a new sof
    start_test();
    for (int k = 0; k < 9; k++) send_pix({4'h5, 4'(k / W), 4'(k % W)}, k == 0, 0);
    send_frame(4'h6, 1'b1, 0);
    drain_and_clear();
    chk("t4_windows", 128'(win_cnt), 128'd4);
    chk("t4_frame_done", 128'(fd_cnt), 128'd1);
    chk("t4_first_data", 128'(first_data), 128'h611610612601621600602620622);

    // asynchronous reset mid-frame, right after window (1,1) was registered
    start_test();
    for (int k = 0; k < 11; k++) send_pix({4'h7, 4'(k / W), 4'(k % W)}, k == 0, 0);
    #2;
    reset         = 1'b0;
    ifc.pix_valid = 1'b0;
    exp_q.delete();
    pos = 0;
    #1;
    chk("t5_async_color", 128'(ifc.color_data), 128'd0);
    chk("t5_async_valid", 128'(ifc.window_valid), 128'd0);
    chk("t5_async_xy", 128'({ifc.win_x, ifc.win_y}), 128'd0);
    chk("t5_async_done", 128'(ifc.frame_done), 128'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    start_test();
    send_frame(4'h8, 1'b0, 0);
    drain_and_clear();
    chk("t5_windows", 128'(win_cnt), 128'd4);
    chk("t5_frame_done", 128'(fd_cnt), 128'd1);
    chk("t5_first_data", 128'(first_data), 128'h811810812801821800802820822);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
